// File: rtl/cpu_pkg.sv
// Shared widths, opcode constants and FSM state type for the single-cycle CPU.
package cpu_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and the valid/ready output register.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_target;
  logic               dec_ready;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic [PC_W-1:0]    if_pcp1;
  logic               halted;

  // Fetch stage side
  modport master (
    output imem_addr, if_valid, if_instr, if_pc, if_pcp1, halted,
    input  imem_rdata, redirect_valid, redirect_target, dec_ready
  );

  // Memory / downstream side
  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, if_pcp1, halted,
    output imem_rdata, redirect_valid, redirect_target, dec_ready
  );

endinterface : fetch_stage_if

// File: rtl/pc_reg.sv
// Program counter: redirect mux over a +1 incrementer, with load enable.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(0)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            inc_en,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next
);

  // Wraps modulo 2^PC_W
  assign pc_next = pc + PC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_en) begin
      pc <= redirect_target;
    end else if (inc_en) begin
      pc <= pc_next;
    end
  end

endmodule : pc_reg

// File: rtl/fetch_stage.sv
// Instruction fetch: BOOT/RUN/HALT control, PC register and registered fetch output.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(0)
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_next;
  logic               redirect_take;
  logic               load;
  logic               drain;
  logic               halt_set;
  logic               loadable;
  logic               is_halt_op;

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    ipc_q;
  logic [PC_W-1:0]    pcp1_q;
  logic               halted_q;

  assign loadable   = !valid_q || bus.dec_ready;
  assign is_halt_op = (bus.imem_rdata[INSTR_W-1 -: OP_W] == OP_HALT);

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_en     (redirect_take),
    .redirect_target (bus.redirect_target),
    .inc_en          (load),
    .pc              (pc),
    .pc_next         (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect beats fetch; HALT ignores redirects and only drains the pending word
  always_comb begin
    state_d       = state_q;
    redirect_take = 1'b0;
    load          = 1'b0;
    drain         = 1'b0;
    halt_set      = 1'b0;
    case (state_q)
      BOOT: begin
        state_d       = RUN;
        redirect_take = bus.redirect_valid;
      end
      RUN: begin
        if (bus.redirect_valid) begin
          redirect_take = 1'b1;
        end else if (loadable) begin
          load = 1'b1;
          if (is_halt_op) begin
            halt_set = 1'b1;
            state_d  = HALT;
          end
        end
      end
      HALT: begin
        drain = valid_q && bus.dec_ready;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      instr_q  <= '0;
      ipc_q    <= '0;
      pcp1_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      if (redirect_take || drain) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
        instr_q <= bus.imem_rdata;
        ipc_q   <= pc;
        pcp1_q  <= pc_next;
      end
      if (halt_set) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign bus.imem_addr = pc;
  assign bus.if_valid  = valid_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ipc_q;
  assign bus.if_pcp1   = pcp1_q;
  assign bus.halted    = halted_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios pinned by literals, then random traffic vs. a model.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] mem [256];

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_rdata = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 = boot, 1 = running, 2 = halted
  int          m_mode;
  logic [7:0]  m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [7:0]  m_ipc;
  logic [7:0]  m_pcp1;
  logic        m_halt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_pc    <= 8'h00;
      m_valid <= 1'b0;
      m_instr <= 32'h0;
      m_ipc   <= 8'h00;
      m_pcp1  <= 8'h00;
      m_halt  <= 1'b0;
    end else if (m_mode != 2 && bus.redirect_valid) begin
      m_pc    <= bus.redirect_target;
      m_valid <= 1'b0;
      m_mode  <= 1;
    end else if (m_mode == 0) begin
      m_mode <= 1;
    end else if (m_mode == 1) begin
      if (!m_valid || bus.dec_ready) begin
        m_instr <= mem[m_pc];
        m_ipc   <= m_pc;
        m_pcp1  <= m_pc + 8'd1;
        m_pc    <= m_pc + 8'd1;
        m_valid <= 1'b1;
        if (mem[m_pc][31:26] == 6'h3F) begin
          m_mode <= 2;
          m_halt <= 1'b1;
        end
      end
    end else begin
      if (bus.dec_ready) m_valid <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("m_valid",  32'(bus.if_valid),  32'(m_valid));
    check("m_addr",   32'(bus.imem_addr), 32'(m_pc));
    check("m_instr",  bus.if_instr,       m_instr);
    check("m_pc",     32'(bus.if_pc),     32'(m_ipc));
    check("m_pcp1",   32'(bus.if_pcp1),   32'(m_pcp1));
    check("m_halted", 32'(bus.halted),    32'(m_halt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int halt_cycles;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 8'h00;
    bus.dec_ready       = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 + 32'(i);
    mem[0]    = 32'h2001_0005;
    mem[1]    = 32'h2002_0007;
    mem[2]    = 32'h2003_0009;
    mem[3]    = 32'h2004_000B;
    mem[8'h40] = 32'h1234_5678;
    mem[8'hFF] = 32'hAABB_CCDD;

    tick();
    tick();
    check("rst_valid", 32'(bus.if_valid), 32'd0);
    check("rst_addr",  32'(bus.imem_addr), 32'd0);
    check("rst_halt",  32'(bus.halted), 32'd0);
    rst_n = 1'b1;

    // Free run: first edge is BOOT, second fetches mem[0]
    tick();
    check("boot_valid", 32'(bus.if_valid), 32'd0);
    tick();
    check("run0_instr", bus.if_instr, 32'h2001_0005);
    check("run0_pc",    32'(bus.if_pc), 32'h00);
    check("run0_pcp1",  32'(bus.if_pcp1), 32'h01);
    tick();
    check("run1_instr", bus.if_instr, 32'h2002_0007);
    check("run1_pc",    32'(bus.if_pc), 32'h01);
    tick();

    // Stall at if_pc=2
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc",    32'(bus.if_pc), 32'h02);
      check("stall_addr",  32'(bus.imem_addr), 32'h03);
      check("stall_instr", bus.if_instr, 32'h2003_0009);
      check("stall_valid", 32'(bus.if_valid), 32'd1);
    end
    bus.dec_ready = 1'b1;
    tick();
    check("release_pc", 32'(bus.if_pc), 32'h03);

    // Redirect while stalled
    bus.dec_ready = 1'b0;
    tick();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'h40;
    tick();
    check("redir_valid", 32'(bus.if_valid), 32'd0);
    check("redir_addr",  32'(bus.imem_addr), 32'h40);
    bus.redirect_valid = 1'b0;
    bus.dec_ready      = 1'b1;
    tick();
    check("redir_pc",    32'(bus.if_pc), 32'h40);
    check("redir_instr", bus.if_instr, 32'h1234_5678);

    // Wrap-around
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'hFF;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("wrap_pc",   32'(bus.if_pc), 32'hFF);
    check("wrap_pcp1", 32'(bus.if_pcp1), 32'h00);
    tick();
    check("wrap_next_pc",    32'(bus.if_pc), 32'h00);
    check("wrap_next_instr", bus.if_instr, 32'h2001_0005);

    // Halt
    mem[3] = 32'hFC00_0000;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'h03;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("halt_pc",     32'(bus.if_pc), 32'h03);
    check("halt_instr",  bus.if_instr, 32'hFC00_0000);
    check("halt_flag",   32'(bus.halted), 32'd1);
    check("halt_addr",   32'(bus.imem_addr), 32'h04);
    tick();
    check("halt_drain",  32'(bus.if_valid), 32'd0);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'h10;
    tick();
    check("halt_ignore_addr",  32'(bus.imem_addr), 32'h04);
    check("halt_ignore_valid", 32'(bus.if_valid), 32'd0);
    bus.redirect_valid = 1'b0;

    // Asynchronous reset in the middle of a stall
    reset_pulse();
    tick();
    tick();
    tick();
    bus.dec_ready = 1'b0;
    tick();
    check("pre_areset_pc", 32'(bus.if_pc), 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valid", 32'(bus.if_valid), 32'd0);
    check("areset_instr", bus.if_instr, 32'd0);
    check("areset_pc",    32'(bus.if_pc), 32'd0);
    check("areset_halt",  32'(bus.halted), 32'd0);
    check("areset_addr",  32'(bus.imem_addr), 32'h00);
    tick();
    rst_n = 1'b1;

    // Random traffic, program with sparse HALT words
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 11) == 0) mem[i][31:26] = 6'h3F;
      else if (mem[i][31:26] == 6'h3F) mem[i][26] = 1'b0;
    end
    halt_cycles = 0;
    for (int c = 0; c < 4000; c++) begin
      bus.dec_ready       = ($urandom_range(0, 3) != 0);
      bus.redirect_valid  = ($urandom_range(0, 9) == 0);
      bus.redirect_target = 8'($urandom);
      halt_cycles = m_halt ? halt_cycles + 1 : 0;
      if (halt_cycles > 6 || $urandom_range(0, 299) == 0) begin
        halt_cycles = 0;
        reset_pulse();
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the 8-bit-address single-cycle CPU. It owns the program counter, drives the combinational instruction-memory read port, and registers each fetched word together with its PC and PC+1 into an output register. The control unit and register-file read stage downstream consume that register through a valid/ready handshake. Downstream can redirect the PC for jumps and branches, and a HALT opcode stops fetching.

## Interface
- `PC_W`, 8: PC / instruction-memory address width.
- `INSTR_W`, 32: instruction width.
- `RESET_PC`, 8'h00: PC value loaded on reset.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_addr`  out  PC_W: instruction-memory address. Equals the PC register; combinational from state.
- `imem_rdata`  in  INSTR_W: instruction-memory read data, combinational from `imem_addr`.
- `redirect_valid`  in  1: load a new PC this cycle.
- `redirect_target`  in  PC_W: new PC value.
- `dec_ready`  in  1: downstream accepts the output register this cycle.
- `if_valid`  out  1: output register holds a valid instruction.
- `if_instr`  out  INSTR_W: fetched instruction.
- `if_pc`  out  PC_W: address of `if_instr`.
- `if_pcp1`  out  PC_W: `if_pc + 1`, modulo 2^PC_W.
- `halted`  out  1: the stage is in HALT.

## Operation
- FSM states: BOOT, RUN, HALT.
- BOOT
  - Entered on reset. Lasts exactly one cycle, then moves to RUN.
  - No fetch occurs in BOOT.
- RUN
  - The output register is loadable when `!if_valid || dec_ready`.
  - On a load: `if_instr <= imem_rdata`, `if_pc <= pc`, `if_pcp1 <= pc+1`, `if_valid <= 1`, `pc <= pc+1`.
  - When not loadable, the PC and the output register hold.
  - If the loaded word has `imem_rdata[31:26] == OP_HALT` (6'h3F), the word is still delivered and the FSM moves to HALT.
- Redirect (`redirect_valid=1`) has the highest priority in BOOT and RUN:
  - `pc <= redirect_target` and `if_valid <= 0` (flush), regardless of `dec_ready`.
  - No load occurs that cycle.
  - The FSM stays in, or enters, RUN. A HALT word fetched in the same cycle is discarded and does not halt.
- HALT
  - Terminal until reset. `pc` is frozen and `redirect_valid` is ignored.
  - A pending valid output is still delivered once `dec_ready` is high, after which `if_valid` stays 0.
- Arithmetic: PC+1 wraps, so 8'hFF + 1 = 8'h00. There is no overflow flag.

## Timing
- Reset values (asynchronous):
  - `pc`/`imem_addr` = `RESET_PC`; state = BOOT.
  - `if_valid`, `if_instr`, `if_pc`, `if_pcp1`, `halted` = 0.
- After `rst_n` rises, the first rising edge is spent in BOOT. The second edge loads `mem[RESET_PC]`, so `if_valid=1` from that point.
- Latency: one cycle from `imem_addr = A` (with the output register loadable) to `if_instr = mem[A]`.
- Throughput: one instruction per cycle while `dec_ready=1`.
- Stall: while `if_valid && !dec_ready`, all outputs and `imem_addr` are stable.
- Redirect: `if_valid=0` the cycle after the redirect; `mem[target]` is valid the cycle after that (bubble of 1).
- `halted` rises on the same edge that loads the HALT word.
- Asserting `rst_n` low at any point, including mid-stall, mid-redirect or in HALT, forces the reset values immediately.

## Structure
- Shared package `cpu_pkg` holds:
  - `PC_W`
  - `INSTR_W`
  - `localparam OP_HALT = 6'h3F`
  - `typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t`
- One sub-module, `pc_reg`. It is the PC register with async active-low reset, load-enable, redirect mux and +1 incrementer. It exposes `pc` and `pc_next`.
- The FSM and the output register live in `fetch_stage`.

## Test plan
- **Reset, then free run:** mem[0]=32'h2001_0005, mem[1]=32'h2002_0007, `dec_ready=1`.
  - Cycle 2 after reset release: `if_instr`=32'h2001_0005, `if_pc`=0, `if_pcp1`=1.
  - Cycle 3: `if_instr`=32'h2002_0007, `if_pc`=1.
- **Stall:** hold `dec_ready=0` for 3 cycles while `if_valid=1` with `if_pc`=2.
  - Outputs and `imem_addr`=3 are unchanged for all 3 cycles.
  - On release, `if_pc`=3 on the next cycle.
- **Redirect during stall:** `redirect_valid=1`, `redirect_target`=8'h40, `dec_ready=0`.
  - Next cycle: `if_valid`=0, `imem_addr`=8'h40.
  - Cycle after: `if_pc`=8'h40, `if_instr`=mem[8'h40].
- **Wrap-around:** redirect to 8'hFF.
  - `if_pc`=8'hFF, `if_pcp1`=8'h00.
  - Next fetch has `if_pc`=8'h00.
- **Halt:** mem[3]=32'hFC00_0000.
  - Word delivered with `if_pc`=3; `halted`=1 on the same edge; `imem_addr` frozen at 4.
  - After the handshake, `if_valid` stays 0 and a later `redirect_valid` has no effect.
- **Asynchronous reset:** drive `rst_n` low mid-stall, between clock edges.
  - `if_valid`, `if_instr`, `if_pc` and `halted` go to 0 and `imem_addr` goes to `RESET_PC` without waiting for a clock edge.
